lsu_dmem: RTL

Parametrised load/store data memory for the RV32I core. It replaces the flat word-only combinational data RAM with a synchronous, handshaked unit. The unit supports byte, halfword and word accesses with sign or zero extension, byte-lane writes, configurable wait states, and misalignment and decode error reporting. It sits between the ALU address output, the register-file rs2 read port, and the write-back mux; the core stalls on `req_ready`/`rsp_valid`.

---
 rtl/lsu_dmem_if.sv | 24 ++
 rtl/lsu_dmem.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_if.sv
// Request/response bundle between the RV32I core and lsu_dmem.
// The core is the master and the data memory unit is the slave.
interface lsu_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/lsu_dmem.sv
// Handshaked RV32I load/store data memory: byte/half/word accesses, wait states, error reporting.
// Define LSU_RANGE_CHECK_EN to reject addresses above the memory instead of aliasing them.
module lsu_dmem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      reset,
    lsu_dmem_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam bit         HAS_WAIT    = (WAIT_STATES != 0);
    localparam logic [3:0] CNT_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;

    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;

    logic [31:0]         r_mem [DEPTH];

    logic                w_req_ready;
    logic                w_rsp_valid;
    logic                w_busy;
    logic                w_accept;
    logic                w_do_access;

    logic                w_acc_we;
    logic [2:0]          w_acc_funct3;
    logic [31:0]         w_acc_addr;
    logic [31:0]         w_acc_wdata;

    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;

    logic                w_funct3_ok;
    logic                w_misalign;
    logic                w_range_err;
    logic                w_err;

    logic [3:0]          w_be;
    logic [31:0]         w_wdata_lanes;
    logic                w_mem_we;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_busy       = 1'b1;
        w_do_access  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy      = 1'b0;
                w_req_ready = !reset;
                if (!reset && bus.req_valid) begin
                    if (HAS_WAIT) begin
                        w_state_next = ST_WAIT;
                    end else begin
                        w_state_next = ST_RESP;
                        w_do_access  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                    w_do_access  = !reset;
                end
            end
            ST_RESP: begin
                w_rsp_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_req_ready && bus.req_valid;

    // ------------------------------------------------------------------
    // Request capture and wait-state counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt    <= CNT_INIT;
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Zero-wait accesses happen on the accept edge, before capture is visible.
    assign w_acc_we     = (r_state == ST_IDLE) ? bus.req_we     : r_we;
    assign w_acc_funct3 = (r_state == ST_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_acc_addr   = (r_state == ST_IDLE) ? bus.req_addr   : r_addr;
    assign w_acc_wdata  = (r_state == ST_IDLE) ? bus.req_wdata  : r_wdata;

    // ------------------------------------------------------------------
    // Access decode and error detection
    // ------------------------------------------------------------------
    always_comb begin
        w_funct3_ok = 1'b0;
        case (w_acc_funct3)
            3'b000, 3'b001, 3'b010: w_funct3_ok = 1'b1;
            3'b100, 3'b101:         w_funct3_ok = !w_acc_we;
            default:                w_funct3_ok = 1'b0;
        endcase
    end

    assign w_misalign = ((w_acc_funct3[1:0] == 2'b01) && w_acc_addr[0]) ||
                        ((w_acc_funct3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
    assign w_range_err = |w_acc_addr[31:ADDR_W+2];
`else
    logic w_unused_addr_hi;
    assign w_range_err      = 1'b0;
    assign w_unused_addr_hi = ^w_acc_addr[31:ADDR_W+2];
`endif

    assign w_err = !w_funct3_ok || w_misalign || w_range_err;

    // ------------------------------------------------------------------
    // Load data path
    // ------------------------------------------------------------------
    assign w_idx  = w_acc_addr[ADDR_W+1:2];
    assign w_lane = w_acc_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = 32'd0;
        case (w_acc_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane enables and data replication
    // ------------------------------------------------------------------
    always_comb begin
        w_be          = 4'b1111;
        w_wdata_lanes = w_acc_wdata;
        case (w_acc_funct3[1:0])
            2'b00: begin
                w_be          = 4'b0001 << w_lane;
                w_wdata_lanes = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_wdata_lanes = w_acc_wdata;
            end
        endcase
    end

    assign w_mem_we = w_do_access && w_acc_we && !w_err;

    // NOTE: the data array is deliberately left out of reset; clearing a RAM
    // needs a per-word write port sweep and would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers: hold until the next completed access
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_do_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : w_load_data;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = w_busy;

endmodule
